// File: rtl/pe_pkg.sv
// Shared defaults and types for the PE accumulator stage.
package pe_pkg;

  localparam int DEF_P_W       = 12;
  localparam int DEF_ACC_W     = 16;
  localparam int DEF_MAX_TERMS = 32;
  localparam int DEF_CNT_W     = 6;

  localparam logic [DEF_ACC_W-1:0] SAT_MAX = {DEF_ACC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/pe_sat_add.sv
// Combinational unsigned saturating adder: ACC_W accumulator plus P_W term.
module pe_sat_add #(
  parameter int ACC_W = 16,
  parameter int P_W   = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [P_W-1:0]   b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry out of the accumulator width.
  assign wide = {1'b0, a} + (ACC_W + 1)'(b);
  assign ovf  = wide[ACC_W];
  assign sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/pe_accum.sv
// Packet accumulator: sums multiplier products into a saturating dot-product
// result and presents it on a valid/ready port.
module pe_accum
  import pe_pkg::*;
#(
  parameter int P_W       = DEF_P_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_TERMS = DEF_MAX_TERMS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Handshake: a beat transfers on a rising edge where valid & ready (and en)
  // are all high; the producer keeps data stable while valid is waiting.

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             at_max;

  pe_sat_add #(
    .ACC_W (ACC_W),
    .P_W   (P_W)
  ) u_sat_add (
    .a   (acc),
    .b   (in_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign in_ready = en & (state != HOLD);
  assign cnt_next = cnt + CNT_W'(1);
  assign ovf_next = ovf | add_ovf;
  assign at_max   = (cnt_next == CNT_W'(MAX_TERMS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= ACC_W'(in_prod);
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
            if (in_last || MAX_TERMS == 1) begin
              out_sum   <= ACC_W'(in_prod);
              out_count <= CNT_W'(1);
              out_ovf   <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= ovf_next;
            // in_last and the term limit on the same beat end one packet only.
            if (in_last || at_max) begin
              out_sum   <= add_sum;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
